// File: rtl/mem_stage.sv
// Memory-access stage after the ALU: runs req/ack data-memory accesses for ldr/str,
// passes every other op straight to writeback and resolves beq as a branch-taken pulse.
module mem_stage #(
  parameter int RD_W    = 3,
  parameter int TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      in_op,
  input  logic [15:0]     in_alu_out,
  input  logic            in_zero,
  input  logic [15:0]     in_store_data,
  input  logic [RD_W-1:0] in_rd,
  output logic            mem_req,
  output logic            mem_we,
  output logic [15:0]     mem_addr,
  output logic [15:0]     mem_wdata,
  input  logic            mem_ack,
  input  logic [15:0]     mem_rdata,
  output logic            wb_valid,
  output logic [15:0]     wb_data,
  output logic [RD_W-1:0] wb_rd,
  output logic            wb_reg_write,
  output logic            br_taken,
  output logic            mem_err
);

  // Opcode encoding shared with the rest of the cpu_16bit datapath.
  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_ADDI = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_NOT  = 4'd6;
  localparam logic [3:0] OP_SLT  = 4'd7;
  localparam logic [3:0] OP_LSL  = 4'd8;
  localparam logic [3:0] OP_LSR  = 4'd9;
  localparam logic [3:0] OP_LDR  = 4'd10;
  localparam logic [3:0] OP_STR  = 4'd11;
  localparam logic [3:0] OP_BEQ  = 4'd12;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [7:0]      r_cnt;
  logic [RD_W-1:0] r_rd;
  logic            r_is_ldr;

  logic w_accept;
  logic w_is_mem;
  logic w_alu_write;
  logic w_timeout;

  assign in_ready    = (r_state == S_IDLE);
  assign w_accept    = in_valid && in_ready;
  assign w_is_mem    = (in_op == OP_LDR) || (in_op == OP_STR);
  assign w_alu_write = (in_op == OP_ADD) || (in_op == OP_ADDI) || (in_op == OP_SUB) ||
                       (in_op == OP_AND) || (in_op == OP_OR)   || (in_op == OP_XOR) ||
                       (in_op == OP_NOT) || (in_op == OP_SLT)  || (in_op == OP_LSL) ||
                       (in_op == OP_LSR);
  assign w_timeout   = !mem_ack && (r_cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept && w_is_mem) w_state_next = S_WAIT;
      S_WAIT: if (mem_ack || w_timeout) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      wb_valid     <= 1'b0;
      wb_data      <= '0;
      wb_rd        <= '0;
      wb_reg_write <= 1'b0;
      br_taken     <= 1'b0;
      mem_err      <= 1'b0;
      r_cnt        <= '0;
      r_rd         <= '0;
      r_is_ldr     <= 1'b0;
    end else begin
      // Retire and branch signals are single-cycle pulses.
      wb_valid     <= 1'b0;
      wb_reg_write <= 1'b0;
      br_taken     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept && w_is_mem) begin
            mem_req   <= 1'b1;
            mem_addr  <= in_alu_out;
            mem_we    <= (in_op == OP_STR);
            mem_wdata <= (in_op == OP_STR) ? in_store_data : 16'h0000;
            r_rd      <= in_rd;
            r_is_ldr  <= (in_op == OP_LDR);
            r_cnt     <= '0;
          end else if (w_accept) begin
            wb_valid     <= 1'b1;
            wb_data      <= in_alu_out;
            wb_rd        <= in_rd;
            wb_reg_write <= w_alu_write;
            br_taken     <= (in_op == OP_BEQ) && in_zero;
          end
        end
        S_WAIT: begin
          if (mem_ack) begin
            mem_req      <= 1'b0;
            wb_valid     <= 1'b1;
            wb_rd        <= r_rd;
            wb_data      <= r_is_ldr ? mem_rdata : 16'h0000;
            wb_reg_write <= r_is_ldr;
          end else if (w_timeout) begin
            mem_req  <= 1'b0;
            mem_err  <= 1'b1;
            wb_valid <= 1'b1;
            wb_rd    <= r_rd;
            wb_data  <= 16'h0000;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: expected retire records are queued as ops are issued
// and compared when wb_valid pulses; memory handshakes are driven by per-op tasks.
module tb_mem_stage;

  localparam int RD_W    = 3;
  localparam int TIMEOUT = 4;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_LDR = 4'd10;
  localparam logic [3:0] OP_STR = 4'd11;
  localparam logic [3:0] OP_BEQ = 4'd12;
  localparam logic [3:0] OP_BAD = 4'd15;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      in_op;
  logic [15:0]     in_alu_out;
  logic            in_zero;
  logic [15:0]     in_store_data;
  logic [RD_W-1:0] in_rd;
  logic            mem_req;
  logic            mem_we;
  logic [15:0]     mem_addr;
  logic [15:0]     mem_wdata;
  logic            mem_ack;
  logic [15:0]     mem_rdata;
  logic            wb_valid;
  logic [15:0]     wb_data;
  logic [RD_W-1:0] wb_rd;
  logic            wb_reg_write;
  logic            br_taken;
  logic            mem_err;

  typedef struct packed {
    logic [15:0]     data;
    logic [RD_W-1:0] rd;
    logic            we;
    logic            br;
  } retire_t;

  retire_t exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  mem_stage #(.RD_W(RD_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_alu_out(in_alu_out), .in_zero(in_zero), .in_store_data(in_store_data),
    .in_rd(in_rd),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_data(wb_data), .wb_rd(wb_rd),
    .wb_reg_write(wb_reg_write), .br_taken(br_taken), .mem_err(mem_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Retire monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (wb_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_retire", {16'h0, wb_data}, 32'hFFFF_FFFF);
      end else begin
        retire_t e;
        e = exp_q.pop_front();
        $display("retire rd=%0d data=0x%04h we=%0b br=%0b (exp rd=%0d data=0x%04h we=%0b br=%0b)",
                 wb_rd, wb_data, wb_reg_write, br_taken, e.rd, e.data, e.we, e.br);
        check("wb_data", 32'(wb_data), 32'(e.data));
        check("wb_rd", 32'(wb_rd), 32'(e.rd));
        check("wb_reg_write", 32'(wb_reg_write), 32'(e.we));
        check("br_taken", 32'(br_taken), 32'(e.br));
      end
    end else if (rst === 1'b0) begin
      check("br_idle", 32'(br_taken), 32'd0);
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Issue a non-memory op; expects acceptance at the next edge.
  task automatic alu_op(input logic [3:0] op, input logic [15:0] alu, input logic zero,
                        input logic [RD_W-1:0] rd, input logic we, input logic br);
    retire_t e;
    check("in_ready_pre", 32'(in_ready), 32'd1);
    e.data = alu; e.rd = rd; e.we = we; e.br = br;
    exp_q.push_back(e);
    in_valid = 1'b1; in_op = op; in_alu_out = alu; in_zero = zero; in_rd = rd;
    @(posedge clk);
    #1 in_valid = 1'b0;
    check("in_ready_post", 32'(in_ready), 32'd1);
  endtask

  // Issue ldr/str; ack_after = WAIT cycle on which to ack (0 = never ack).
  task automatic mem_op(input logic [3:0] op, input logic [15:0] addr, input logic [15:0] sdata,
                        input logic [RD_W-1:0] rd, input int ack_after, input logic [15:0] rdata);
    retire_t e;
    int k;
    logic is_st;
    is_st = (op == OP_STR);
    if (ack_after == 0 || ack_after > TIMEOUT) begin
      e.data = 16'h0; e.we = 1'b0;
    end else begin
      e.data = is_st ? 16'h0 : rdata; e.we = ~is_st;
    end
    e.rd = rd; e.br = 1'b0;
    exp_q.push_back(e);
    in_valid = 1'b1; in_op = op; in_alu_out = addr; in_store_data = sdata; in_rd = rd;
    @(posedge clk);
    #1;
    // Keep a junk op on the input during WAIT; it must be ignored.
    in_op = OP_ADD; in_alu_out = 16'h7777; in_rd = 3'd7;
    k = 0;
    while (mem_req === 1'b1 && k < 20) begin
      k++;
      check("mem_addr", 32'(mem_addr), 32'(addr));
      check("mem_we", 32'(mem_we), 32'(is_st));
      check("mem_wdata", 32'(mem_wdata), is_st ? 32'(sdata) : 32'd0);
      check("in_ready_wait", 32'(in_ready), 32'd0);
      if (k == ack_after) begin mem_ack = 1'b1; mem_rdata = rdata; end
      @(posedge clk);
      #1 mem_ack = 1'b0; mem_rdata = 16'hDEAD;
    end
    in_valid = 1'b0;
    check("req_cycles", 32'(k), (ack_after == 0) ? 32'(TIMEOUT) : 32'(ack_after));
    check("in_ready_done", 32'(in_ready), 32'd1);
    $display("mem op=%0d addr=0x%04h req_cycles=%0d mem_err=%0b", op, addr, k, mem_err);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    in_valid = 0; in_op = 0; in_alu_out = 0; in_zero = 0; in_store_data = 0; in_rd = 0;
    mem_ack = 0; mem_rdata = 0;
    do_reset();
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_wb_valid", 32'(wb_valid), 32'd0);
    check("rst_mem_err", 32'(mem_err), 32'd0);
    check("rst_wb_data", 32'(wb_data), 32'd0);
    check("rst_wb_rd", 32'(wb_rd), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);

    alu_op(OP_ADD, 16'h1234, 1'b0, 3'd5, 1'b1, 1'b0);
    alu_op(OP_BEQ, 16'h0000, 1'b1, 3'd2, 1'b0, 1'b1);
    alu_op(OP_BEQ, 16'h0001, 1'b0, 3'd3, 1'b0, 1'b0);
    alu_op(OP_SUB, 16'hFFFE, 1'b0, 3'd1, 1'b1, 1'b0);
    alu_op(OP_BAD, 16'h5555, 1'b1, 3'd4, 1'b0, 1'b0);
    @(negedge clk);
    check("wb_data_hold", 32'(wb_data), 32'h5555);

    mem_op(OP_LDR, 16'h0040, 16'h0000, 3'd6, 3, 16'hBEEF);
    mem_op(OP_STR, 16'h0010, 16'hA5A5, 3'd2, 1, 16'h0000);
    check("no_err", 32'(mem_err), 32'd0);

    mem_op(OP_LDR, 16'h0080, 16'h0000, 3'd3, 0, 16'h0000);
    check("timeout_err", 32'(mem_err), 32'd1);
    alu_op(OP_ADD, 16'h0042, 1'b0, 3'd1, 1'b1, 1'b0);
    check("err_sticky", 32'(mem_err), 32'd1);

    do_reset();
    check("err_cleared", 32'(mem_err), 32'd0);
    mem_op(OP_LDR, 16'h0090, 16'h0000, 3'd4, TIMEOUT, 16'hC0DE);
    check("ack_wins", 32'(mem_err), 32'd0);

    // Reset on the 2nd WAIT cycle together with an ack: access dropped, no retire.
    in_valid = 1'b1; in_op = OP_LDR; in_alu_out = 16'h0100; in_rd = 3'd5;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1; mem_ack = 1'b1; mem_rdata = 16'h1111;
    @(posedge clk);
    #1 rst = 1'b0;
    check("rst_wait_req", 32'(mem_req), 32'd0);
    check("rst_wait_ready", 32'(in_ready), 32'd1);
    check("rst_wait_wb", 32'(wb_valid), 32'd0);
    repeat (2) @(posedge clk);
    #1 mem_ack = 1'b0;
    check("late_ack_req", 32'(mem_req), 32'd0);
    check("late_ack_wb", 32'(wb_valid), 32'd0);
    $display("reset during WAIT: mem_req=%0b in_ready=%0b", mem_req, in_ready);

    repeat (3) @(posedge clk);
    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
